id_stage: RTL and testbench
===========================

# id_stage

Parametrised instruction-decode pipeline stage for the MIPS-subset core. It sits between the IF/ID register and the EX stage, and its main jobs are:
- Decode the fetched instruction into the 10-bit control word.
- Read two operands from an internal register file, which it also owns and which has a write-back port.
- Sign-extend the immediate.
- Launch one ID/EX bundle per cycle under a ready/valid handshake.
- Insert a load-use bubble and honour a pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath and PC width; must be ≥ 32.
- NREG, 32, number of architectural registers (2..32); reads of index ≥ NREG return 0 and writes to it are ignored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_pc  in  XLEN  PC of that instruction.
- if_instr  in  32  instruction word.
- id_ready  out  1  ID accepts if_instr at this edge (combinational).
- ex_ready  in  1  EX can take a new bundle at this edge.
- flush  in  1  discard the instruction in ID and the bundle in ID/EX.
- wb_en, wb_addr[4:0], wb_data[XLEN-1:0]  in  register-file write port.
- ex_valid  out  1  ID/EX bundle valid.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered PC, operand rs, operand rt, extended immediate.
- ex_rs, ex_rt, ex_rd  out  5  register index fields.
- ex_ctrl  out  10  control word: [9] RegDst, [8] Jump, [7] Branch, [6] MemRead, [5] MemtoReg, [4:3] ALUOp, [2] MemWrite, [1] ALUSrc, [0] RegWrite.
- ex_illegal  out  1  opcode not in the supported set.

## Operation
- Opcode is if_instr[31:26]. ex_ctrl is assigned per opcode:
  - R-type 000000: 1_0_0_0_0_10_0_0_1.
  - lw 100011: 0_0_0_1_1_00_0_1_1.
  - sw 101011: 0_0_0_0_0_00_1_1_0.
  - beq 000100: 0_0_1_0_0_01_0_0_0.
  - addi 001000: 0_0_0_0_0_00_0_1_1.
  - j 000010: 0_1_0_0_0_00_0_0_0.
  - Any other opcode: ex_ctrl = 0 and ex_illegal = 1; ex_valid is still 1.
- ex_imm:
  - j: zero-extended {instr[25:0], 2'b00}.
  - All other opcodes: sign-extended instr[15:0].
- Register file: NREG × XLEN.
  - Register 0 always reads 0; writes to it are dropped.
  - Write happens on the rising edge when rst_n = 1 and wb_en = 1.
  - Write-through bypass: if wb_en, wb_addr ≠ 0 and wb_addr matches rs (or rt), that read returns wb_data in the same cycle.
- Load-use hazard, combinational:
  - Condition: if_valid and ex_valid and ex_ctrl[6] and ex_rt ≠ 0, and one of:
    - ex_rt == instr[25:21], and the opcode uses rs (R, lw, sw, beq, addi); or
    - ex_rt == instr[20:16], and the opcode uses rt (R, sw, beq).
- Ready: id_ready = flush | (ex_ready & ~hazard).
- ID/EX update priority, evaluated at each edge with rst_n = 1:
  1. flush: ex_valid ← 0, ex_ctrl ← 0, ex_illegal ← 0. The input is consumed and dropped. This applies regardless of ex_ready.
  2. ~ex_ready: all ex_* outputs hold.
  3. hazard: bubble. ex_valid ← 0, ex_ctrl ← 0, ex_illegal ← 0; the input is held (not consumed).
  4. Otherwise: ex_valid ← if_valid and all fields load. When if_valid = 0, ex_ctrl ← 0 and ex_illegal ← 0.
- There is no state machine beyond the ID/EX register and the register file. The hazard clears itself after one bubble because the bubble has ex_valid = 0.

## Timing
- Latency: instruction accepted at edge N appears on ex_* after edge N; one cycle.
- Throughput: 1 instruction/cycle without hazards. Each load-use hazard costs exactly one bubble.
- Write-back at edge N is visible to a decode in the same cycle (bypass) and to all later cycles (array).
- Reset (rst_n = 0 at an edge):
  - All ex_* outputs ← 0 and all registers ← 0.
  - The write port is ignored during reset.
  - id_ready still follows its equation, with ex_valid = 0 after the first reset edge.
- Reset mid-stall or mid-hazard: the ID/EX contents are lost and no bubble is pending afterwards.
- Simultaneous flush and hazard: flush wins and there is no stall.
- Simultaneous flush and ~ex_ready: flush wins.

## Test plan
- Reset, then write r5 = 0x0000_0011 and r6 = 0x0000_0022 via wb. Decode add r7,r5,r6 (0x00A63820) -> next cycle:
  - ex_valid = 1, ex_rd1 = 0x11, ex_rd2 = 0x22, ex_rd = 7.
  - ex_ctrl = 10'b1000010001.
- addi r1,r0,-4 (0x2001FFFC) -> ex_imm = 0xFFFF_FFFC, ex_rd1 = 0, ex_ctrl = 10'b0000000011. A wb to r0 with 0xDEAD leaves r0 reading 0.
- lw r2,0(r3), then add r4,r2,r2 back-to-back:
  - id_ready = 0 for one cycle.
  - One bubble appears: ex_valid = 0, ex_ctrl = 0.
  - The add issues on the following cycle.
  - The same sequence with add r4,r8,r9 shows no bubble.
- Bypass: wb_en = 1, wb_addr = 3, wb_data = 0x1234 in the same cycle that decodes an instruction with rs = 3 -> ex_rd1 = 0x1234.
- Backpressure and flush:
  - Hold ex_ready = 0 for 3 cycles -> ex_* stay constant and id_ready = 0.
  - Assert flush with ex_ready = 0 -> ex_valid = 0 next cycle.
- Opcode 111111 -> ex_valid = 1, ex_illegal = 1, ex_ctrl = 0. Assert rst_n = 0 during a stall -> all outputs are 0 next cycle.

Source files
------------

// File: rtl/id_stage_if.sv
// Handshake bundle between the IF/ID register, the decode stage and the ID/EX register.
// The master drives fetch and EX-side readiness; the slave (id_stage) drives the decoded bundle.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_rd;
  logic [9:0]      ex_ctrl;
  logic            ex_illegal;

  modport master (
    output if_valid, if_pc, if_instr, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_ctrl, ex_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// MIPS-subset decode stage: control decode, register file with write-through bypass,
// immediate extension, load-use bubble insertion and flush handling into the ID/EX register.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  id_stage_if.slave       bus,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [9:0] CTRL_R    = 10'b1000010001;
  localparam logic [9:0] CTRL_LW   = 10'b0001100011;
  localparam logic [9:0] CTRL_SW   = 10'b0000000110;
  localparam logic [9:0] CTRL_BEQ  = 10'b0010001000;
  localparam logic [9:0] CTRL_ADDI = 10'b0000000011;
  localparam logic [9:0] CTRL_J    = 10'b0100000000;

  localparam logic [5:0] NREG_W = 6'(NREG);

  logic [5:0]      opcode_s;
  logic [4:0]      rs_s;
  logic [4:0]      rt_s;
  logic [4:0]      rd_s;
  logic [9:0]      ctrl_s;
  logic            illegal_s;
  logic            uses_rs_s;
  logic            uses_rt_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic            hazard_s;

  logic [XLEN-1:0] regs_r [32];

  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [XLEN-1:0] ex_rd1_r;
  logic [XLEN-1:0] ex_rd2_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [4:0]      ex_rs_r;
  logic [4:0]      ex_rt_r;
  logic [4:0]      ex_rd_r;
  logic [9:0]      ex_ctrl_r;
  logic            ex_illegal_r;

  // Out-of-range and r0 reads are zero; a same-cycle write-back overrides the stored value.
  function automatic logic [XLEN-1:0] rf_read(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [4:0]      wa,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] val;
    if ((idx == 5'd0) || ({1'b0, idx} >= NREG_W)) begin
      val = '0;
    end else if (we && (wa == idx)) begin
      val = wd;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign opcode_s = bus.if_instr[31:26];
  assign rs_s     = bus.if_instr[25:21];
  assign rt_s     = bus.if_instr[20:16];
  assign rd_s     = bus.if_instr[15:11];

  // Opcode decode: control word, legality and which source fields are actually read
  always_comb begin
    ctrl_s    = 10'b0;
    illegal_s = 1'b0;
    uses_rs_s = 1'b0;
    uses_rt_s = 1'b0;
    case (opcode_s)
      OP_R:    begin ctrl_s = CTRL_R;    uses_rs_s = 1'b1; uses_rt_s = 1'b1; end
      OP_LW:   begin ctrl_s = CTRL_LW;   uses_rs_s = 1'b1; end
      OP_SW:   begin ctrl_s = CTRL_SW;   uses_rs_s = 1'b1; uses_rt_s = 1'b1; end
      OP_BEQ:  begin ctrl_s = CTRL_BEQ;  uses_rs_s = 1'b1; uses_rt_s = 1'b1; end
      OP_ADDI: begin ctrl_s = CTRL_ADDI; uses_rs_s = 1'b1; end
      OP_J:    begin ctrl_s = CTRL_J; end
      default: begin illegal_s = 1'b1; end
    endcase
  end

  // Immediate extension: jump target is word-aligned and unsigned, everything else sign-extends
  always_comb begin
    if (opcode_s == OP_J) begin
      imm_s = {{(XLEN-28){1'b0}}, bus.if_instr[25:0], 2'b00};
    end else begin
      imm_s = {{(XLEN-16){bus.if_instr[15]}}, bus.if_instr[15:0]};
    end
  end

  // Operand reads with write-through bypass
  always_comb begin
    rd1_s = rf_read(rs_s, regs_r[rs_s], wb_en, wb_addr, wb_data);
    rd2_s = rf_read(rt_s, regs_r[rt_s], wb_en, wb_addr, wb_data);
  end

  // A load in ID/EX whose destination feeds this instruction forces one bubble
  assign hazard_s = bus.if_valid & ex_valid_r & ex_ctrl_r[6] & (ex_rt_r != 5'd0) &
                    (((ex_rt_r == rs_s) & uses_rs_s) | ((ex_rt_r == rt_s) & uses_rt_s));

  assign bus.id_ready = flush | (bus.ex_ready & ~hazard_s);

  // Register file storage; r0 and indices beyond NREG are never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG_W)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // ID/EX register: flush beats backpressure, backpressure beats the load-use bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= '0;
      ex_rd1_r     <= '0;
      ex_rd2_r     <= '0;
      ex_imm_r     <= '0;
      ex_rs_r      <= 5'd0;
      ex_rt_r      <= 5'd0;
      ex_rd_r      <= 5'd0;
      ex_ctrl_r    <= 10'b0;
      ex_illegal_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r   <= 1'b0;
      ex_ctrl_r    <= 10'b0;
      ex_illegal_r <= 1'b0;
    end else if (bus.ex_ready) begin
      if (hazard_s) begin
        ex_valid_r   <= 1'b0;
        ex_ctrl_r    <= 10'b0;
        ex_illegal_r <= 1'b0;
      end else begin
        ex_valid_r   <= bus.if_valid;
        ex_pc_r      <= bus.if_pc;
        ex_rd1_r     <= rd1_s;
        ex_rd2_r     <= rd2_s;
        ex_imm_r     <= imm_s;
        ex_rs_r      <= rs_s;
        ex_rt_r      <= rt_s;
        ex_rd_r      <= rd_s;
        ex_ctrl_r    <= bus.if_valid ? ctrl_s : 10'b0;
        ex_illegal_r <= bus.if_valid ? illegal_s : 1'b0;
      end
    end
  end

  assign bus.ex_valid   = ex_valid_r;
  assign bus.ex_pc      = ex_pc_r;
  assign bus.ex_rd1     = ex_rd1_r;
  assign bus.ex_rd2     = ex_rd2_r;
  assign bus.ex_imm     = ex_imm_r;
  assign bus.ex_rs      = ex_rs_r;
  assign bus.ex_rt      = ex_rt_r;
  assign bus.ex_rd      = ex_rd_r;
  assign bus.ex_ctrl    = ex_ctrl_r;
  assign bus.ex_illegal = ex_illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized traffic, all checked against
// a cycle-level reference model of the decode stage built from opcode tables and a register array.
module tb_id_stage;
  localparam int XLEN = 32;
  localparam int NREG = 16;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  id_stage_if #(.XLEN(XLEN)) bus ();

  id_stage #(.XLEN(XLEN), .NREG(NREG)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .flush   (flush),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    logic        ill;
  } bundle_t;

  bundle_t     m;
  bit          m_known;
  logic [31:0] m_regs [32];
  logic [9:0]  ctrl_of [logic [5:0]];
  int          n_checks;
  int          n_errors;
  logic [31:0] cur_pc;
  bit          consumed;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NREG) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  // One clock of the reference model: ready check before the edge, full bundle check after it.
  task automatic cycle(output bit took);
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit         hz, rdy, legal;
    bundle_t    nx;
    op    = bus.if_instr[31:26];
    rs    = bus.if_instr[25:21];
    rt    = bus.if_instr[20:16];
    legal = ctrl_of.exists(op);
    hz  = m_known && bus.if_valid && m.v && m.ctrl[6] && (m.rt != 5'd0) &&
          ((m.rt == rs && op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000}) ||
           (m.rt == rt && op inside {6'b000000, 6'b101011, 6'b000100}));
    rdy = flush || (bus.ex_ready && !hz);
    @(negedge clk);
    if (m_known) check("id_ready", bus.id_ready, rdy);
    nx = m;
    if (!rst_n) begin
      nx = '{v: 1'b0, pc: 32'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
             rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 10'd0, ill: 1'b0};
    end else if (flush || (bus.ex_ready && hz)) begin
      nx.v = 1'b0; nx.ctrl = 10'd0; nx.ill = 1'b0;
    end else if (bus.ex_ready) begin
      nx.v    = bus.if_valid;
      nx.pc   = bus.if_pc;
      nx.rs   = rs;
      nx.rt   = rt;
      nx.rd   = bus.if_instr[15:11];
      nx.rd1  = m_read(rs);
      nx.rd2  = m_read(rt);
      if (op == 6'b000010) nx.imm = {4'd0, bus.if_instr[25:0], 2'b00};
      else nx.imm = 32'($signed(bus.if_instr[15:0]));
      nx.ctrl = (bus.if_valid && legal) ? ctrl_of[op] : 10'd0;
      nx.ill  = bus.if_valid && !legal;
    end
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (wb_en && wb_addr != 5'd0 && int'(wb_addr) < NREG) begin
      m_regs[wb_addr] = wb_data;
    end
    took = !rst_n || rdy;
    @(posedge clk);
    #1;
    m = nx;
    m_known = 1'b1;
    check("ex_valid",   bus.ex_valid,   m.v);
    check("ex_pc",      bus.ex_pc,      m.pc);
    check("ex_rd1",     bus.ex_rd1,     m.rd1);
    check("ex_rd2",     bus.ex_rd2,     m.rd2);
    check("ex_imm",     bus.ex_imm,     m.imm);
    check("ex_rs",      bus.ex_rs,      m.rs);
    check("ex_rt",      bus.ex_rt,      m.rt);
    check("ex_rd",      bus.ex_rd,      m.rd);
    check("ex_ctrl",    bus.ex_ctrl,    m.ctrl);
    check("ex_illegal", bus.ex_illegal, m.ill);
  endtask

  task automatic drive(input bit rst, input bit v, input logic [31:0] instr, input bit rdy,
                       input bit fl, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    rst_n        = rst;
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = cur_pc;
    bus.ex_ready = rdy;
    flush        = fl;
    wb_en        = we;
    wb_addr      = wa;
    wb_data      = wd;
    cur_pc       = cur_pc + 32'd4;
  endtask

  task automatic peek_ready(input string tag, input bit exp);
    #1;
    check(tag, bus.id_ready, exp);
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = 6'b000000;
      2, 3:    op = 6'b100011;
      4:       op = 6'b101011;
      5:       op = 6'b000100;
      6, 9:    op = 6'b001000;
      7:       op = 6'b000010;
      default: begin
        op = 6'($urandom_range(0, 63));
        if (ctrl_of.exists(op)) op = 6'b111111;
      end
    endcase
    return {op, pick_reg(), pick_reg(), 16'($urandom_range(0, 65535))};
  endfunction

  logic [31:0] issued_pc;

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_of[6'b000000] = 10'b1000010001;
    ctrl_of[6'b100011] = 10'b0001100011;
    ctrl_of[6'b101011] = 10'b0000000110;
    ctrl_of[6'b000100] = 10'b0010001000;
    ctrl_of[6'b001000] = 10'b0000000011;
    ctrl_of[6'b000010] = 10'b0100000000;
    n_checks = 0;
    n_errors = 0;
    m_known  = 1'b0;
    cur_pc   = 32'h0000_1000;

    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hFFFF); cycle(consumed);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);    cycle(consumed);
    check("reset_valid", bus.ex_valid, 1'b0);

    // add r7,r5,r6 after writing r5/r6
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11); cycle(consumed);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h22); cycle(consumed);
    drive(1'b1, 1'b1, 32'h00A63820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    check("add_rd1", bus.ex_rd1, 32'h11);
    check("add_rd2", bus.ex_rd2, 32'h22);
    check("add_rd", bus.ex_rd, 5'd7);
    check("add_ctrl", bus.ex_ctrl, 10'b1000010001);

    // addi r1,r0,-4 with a write to r0 in the same cycle
    drive(1'b1, 1'b1, 32'h2001FFFC, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD); cycle(consumed);
    check("addi_imm", bus.ex_imm, 32'hFFFF_FFFC);
    check("addi_rd1", bus.ex_rd1, 32'd0);
    check("addi_ctrl", bus.ex_ctrl, 10'b0000000011);
    drive(1'b1, 1'b1, 32'h00000820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    check("r0_reads_zero", bus.ex_rd1, 32'd0);

    // lw r2,0(r3) then dependent add r4,r2,r2: one bubble
    drive(1'b1, 1'b1, 32'h8C620000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    drive(1'b1, 1'b1, 32'h00422020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    peek_ready("hazard_ready", 1'b0);
    cycle(consumed);
    check("bubble_valid", bus.ex_valid, 1'b0);
    check("bubble_ctrl", bus.ex_ctrl, 10'd0);
    cycle(consumed);
    check("after_bubble_valid", bus.ex_valid, 1'b1);
    check("after_bubble_rd", bus.ex_rd, 5'd4);

    // lw then independent add r4,r8,r9: no bubble
    drive(1'b1, 1'b1, 32'h8C620000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    drive(1'b1, 1'b1, 32'h01092020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    peek_ready("nohazard_ready", 1'b1);
    cycle(consumed);
    check("nohazard_valid", bus.ex_valid, 1'b1);

    // bypass: write r3 while decoding addi r1,r3,1
    drive(1'b1, 1'b1, 32'h20610001, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1234); cycle(consumed);
    check("bypass_rd1", bus.ex_rd1, 32'h1234);

    // backpressure for three cycles, then flush while still stalled
    issued_pc = cur_pc;
    drive(1'b1, 1'b1, 32'h00A63820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h8C620000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      peek_ready("stall_ready", 1'b0);
      cycle(consumed);
    end
    check("stall_pc_held", bus.ex_pc, issued_pc);
    check("stall_valid_held", bus.ex_valid, 1'b1);
    drive(1'b1, 1'b1, 32'h8C620000, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cycle(consumed);
    check("flush_valid", bus.ex_valid, 1'b0);

    // illegal opcode, then reset while stalled
    drive(1'b1, 1'b1, 32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    check("illegal_flag", bus.ex_illegal, 1'b1);
    check("illegal_valid", bus.ex_valid, 1'b1);
    check("illegal_ctrl", bus.ex_ctrl, 10'd0);
    drive(1'b0, 1'b1, 32'h00A63820, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55); cycle(consumed);
    check("rst_stall_valid", bus.ex_valid, 1'b0);
    check("rst_stall_pc", bus.ex_pc, 32'd0);
    check("rst_stall_illegal", bus.ex_illegal, 1'b0);
    drive(1'b1, 1'b1, 32'h00A63820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cycle(consumed);
    check("rst_cleared_regs", bus.ex_rd1, 32'd0);

    // randomized traffic; the fetch side holds an instruction until it is consumed
    consumed = 1'b1;
    for (int n = 0; n < 800; n++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      bus.ex_ready = ($urandom_range(0, 4) != 0);
      wb_en        = ($urandom_range(0, 2) == 0);
      wb_addr      = pick_reg();
      wb_data      = $urandom;
      if (consumed) begin
        bus.if_valid = ($urandom_range(0, 6) != 0);
        bus.if_instr = gen_instr();
        bus.if_pc    = cur_pc;
        cur_pc       = cur_pc + 32'd4;
      end
      cycle(consumed);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
